// File: rtl/psx_pkg.sv
// rtl/psx_pkg.sv - shared constants, state encoding and response byte table for the PSX pad controller
package psx_pkg;

  localparam logic [7:0] START_CMD    = 8'h01;
  localparam logic [7:0] BEGIN_TX_CMD = 8'h42;
  localparam logic [7:0] PREAMBLE     = 8'h5A;
  localparam logic [7:0] DEFAULT_ID   = 8'h73;
  localparam int         NUM_BYTES    = 9;
  localparam logic [3:0] LAST_BYTE    = 4'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_XFER     = 3'd1,
    ST_ACK_WAIT = 3'd2,
    ST_ACK_LOW  = 3'd3,
    ST_IGNORE   = 3'd4
  } psx_state_e;

  // Response byte for a given position in the poll; sticks are packed {rx, ry, lx, ly}
  function automatic logic [7:0] resp_byte(input logic [3:0]  idx,
                                           input logic [7:0]  id,
                                           input logic [15:0] btn,
                                           input logic [31:0] stick);
    case (idx)
      4'd0:    resp_byte = 8'hFF;
      4'd1:    resp_byte = id;
      4'd2:    resp_byte = PREAMBLE;
      4'd3:    resp_byte = btn[7:0];
      4'd4:    resp_byte = btn[15:8];
      4'd5:    resp_byte = stick[31:24];
      4'd6:    resp_byte = stick[23:16];
      4'd7:    resp_byte = stick[15:8];
      4'd8:    resp_byte = stick[7:0];
      default: resp_byte = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/psx_sync.sv
// rtl/psx_sync.sv - two-flop synchronizer with rise/fall pulses on the synchronized level
module psx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Capture the pin twice, then keep one more stage to detect edges on the clean level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/psx_controller.sv
// rtl/psx_controller.sv - PSX analog pad responder: serial poll engine with per-byte ack
module psx_controller
  import psx_pkg::*;
#(
  parameter int         ACK_DELAY = 10,
  parameter int         ACK_WIDTH = 4,
  parameter logic [7:0] DEVICE_ID = DEFAULT_ID
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] button_state,
  input  logic [31:0] stick_state,
  output logic        data,
  output logic        ack,
  output logic        active,
  output logic        poll_done
);

  logic att_s, att_rise, att_fall;
  logic pclk_s, pclk_rise, pclk_fall;
  logic cmd_s, cmd_rise, cmd_fall;
  logic sync_unused;

  psx_sync u_sync_att  (.clk(clk), .rst_n(rst_n), .async_i(att),
                        .sync_o(att_s), .rise_o(att_rise), .fall_o(att_fall));
  psx_sync u_sync_pclk (.clk(clk), .rst_n(rst_n), .async_i(psx_clk),
                        .sync_o(pclk_s), .rise_o(pclk_rise), .fall_o(pclk_fall));
  psx_sync u_sync_cmd  (.clk(clk), .rst_n(rst_n), .async_i(cmd),
                        .sync_o(cmd_s), .rise_o(cmd_rise), .fall_o(cmd_fall));

  assign sync_unused = att_rise | pclk_s | cmd_rise | cmd_fall;

  psx_state_e  state_q, state_d;
  logic [3:0]  byte_q, byte_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] btn_q, btn_d;
  logic [31:0] stick_q, stick_d;
  logic        data_q, data_d;
  logic        done_q, done_d;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  logic [7:0]  cmd_full;
  logic [7:0]  resp_cur;

  // State register plus all datapath registers of the poll engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      byte_q   <= '0;
      bit_q    <= '0;
      cmd_q    <= '0;
      cnt_q    <= '0;
      btn_q    <= 16'hFFFF;
      stick_q  <= 32'h80808080;
      data_q   <= 1'b1;
      done_q   <= 1'b0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      bit_q    <= bit_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_d;
      stick_q  <= stick_d;
      data_q   <= data_d;
      done_q   <= done_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

  // Command byte as it would look with the current cmd bit merged in; full byte on the 8th rise
  always_comb begin
    cmd_full        = cmd_q;
    cmd_full[bit_q] = cmd_s;
  end

  assign resp_cur = resp_byte(byte_q, DEVICE_ID, btn_q, stick_q);

  // Next-state logic: poll sequencing, ack timing, data bit selection and abort on att high
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    btn_d    = btn_q;
    stick_d  = stick_q;
    data_d   = data_q;
    done_d   = 1'b0;
    // The synchronizer chain holds reset values for a few cycles; only trust att once it has
    // flushed, so a poll already in progress when reset releases is never joined midway.
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd3) & att_s);

    case (state_q)
      ST_IDLE: begin
        if (att_fall && armed_q) begin
          state_d = ST_XFER;
          byte_d  = '0;
          bit_d   = '0;
          btn_d   = button_state;
          stick_d = stick_state;
        end
      end
      ST_XFER: begin
        if (pclk_fall) begin
          data_d = resp_cur[bit_q];
        end else if (pclk_rise) begin
          cmd_d = cmd_full;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (byte_q == LAST_BYTE) begin
              state_d = ST_IGNORE;
              done_d  = 1'b1;
            end else if ((byte_q == 4'd0 && cmd_full != START_CMD) ||
                         (byte_q == 4'd1 && cmd_full != BEGIN_TX_CMD)) begin
              state_d = ST_IGNORE;
            end else begin
              state_d = ST_ACK_WAIT;
              cnt_d   = '0;
            end
          end
        end
      end
      ST_ACK_WAIT: begin
        if (cnt_q == 16'(ACK_DELAY - 1)) begin
          state_d = ST_ACK_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ACK_LOW: begin
        if (cnt_q == 16'(ACK_WIDTH - 1)) begin
          state_d = ST_XFER;
          byte_d  = byte_q + 4'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IGNORE: begin
        state_d = ST_IGNORE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (att_s) begin
      state_d = ST_IDLE;
    end
    if (state_d != ST_XFER) begin
      data_d = 1'b1;
    end
  end

  // Outputs decoded from the current state; data and poll_done come straight from registers
  always_comb begin
    ack       = (state_q != ST_ACK_LOW);
    active    = (state_q == ST_XFER) || (state_q == ST_ACK_WAIT) || (state_q == ST_ACK_LOW);
    data      = data_q;
    poll_done = done_q;
  end

endmodule

// File: tb/tb_psx_controller.sv
// tb/tb_psx_controller.sv - randomized console-side bench with response-byte scoreboard
`timescale 1ns/1ps
module tb_psx_controller;

  localparam int         ACK_DELAY = 10;
  localparam int         ACK_WIDTH = 4;
  localparam logic [7:0] DEV_ID    = 8'h73;
  localparam int         HALF      = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        att = 1'b1;
  logic        psx_clk = 1'b1;
  logic        cmd = 1'b1;
  logic [15:0] button_state = 16'hFFFF;
  logic [31:0] stick_state = 32'h80808080;
  logic        data, ack, active, poll_done;

  always #250 clk = ~clk;

  psx_controller #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH), .DEVICE_ID(DEV_ID)) dut (
    .clk(clk), .rst_n(rst_n), .att(att), .psx_clk(psx_clk), .cmd(cmd),
    .button_state(button_state), .stick_state(stick_state),
    .data(data), .ack(ack), .active(active), .poll_done(poll_done)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         ack_pulses = 0;
  int         done_pulses = 0;
  int         ack_w = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: console view of data, sampled on psx_clk rising edges, compared byte by byte
  initial begin : mon_data
    logic [7:0] sh;
    logic [7:0] e;
    int n;
    n = 0;
    sh = '0;
    forever begin
      @(posedge psx_clk or posedge att or negedge rst_n);
      if (att || !rst_n) begin
        n = 0;
      end else begin
        sh[n] = data;
        n++;
        if (n == 8) begin
          n = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h expected=none", sh);
          end else begin
            e = exp_q.pop_front();
            check("data_byte", sh, e);
          end
        end
      end
    end
  end

  // Monitor: width of every ack pulse, and pulse counts of ack and poll_done
  initial begin : mon_ack
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_w = 0;
      end else if (ack === 1'b0) begin
        ack_w++;
      end else if (ack_w > 0) begin
        check("ack_width", ack_w, ACK_WIDTH);
        ack_pulses++;
        ack_w = 0;
      end
      if (poll_done === 1'b1) done_pulses++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_resp(input int k, input logic [15:0] b, input logic [31:0] s);
    logic [7:0] r[9];
    r = '{8'hFF, DEV_ID, 8'h5A, b[7:0], b[15:8], s[31:24], s[23:16], s[15:8], s[7:0]};
    exp_q.push_back(r[k]);
  endtask

  task automatic xfer_byte(input logic [7:0] c, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      psx_clk = 1'b0;
      cmd = c[i];
      cycles(HALF);
      psx_clk = 1'b1;
      cycles(HALF);
    end
  endtask

  task automatic wait_ack(output bit got);
    int t;
    got = 1'b0;
    t = 0;
    while (ack !== 1'b0 && t < ACK_DELAY + 20) begin
      @(negedge clk);
      t++;
    end
    if (ack === 1'b0) begin
      got = 1'b1;
      t = 0;
      while (ack === 1'b0 && t < ACK_WIDTH + 20) begin
        @(negedge clk);
        t++;
      end
    end
    cycles(2);
  endtask

  task automatic start_poll();
    @(negedge clk);
    att = 1'b0;
    cycles(4);
  endtask

  task automatic end_poll();
    @(negedge clk);
    att = 1'b1;
    cycles(4);
  endtask

  task automatic full_poll(input logic [15:0] b, input logic [31:0] s,
                           input bit chg, input logic [15:0] b_mid, input bit rnd_cmd);
    int a0, d0;
    bit got;
    logic [7:0] c;
    button_state = b;
    stick_state = s;
    a0 = ack_pulses;
    d0 = done_pulses;
    start_poll();
    check("active_start", active, 1);
    for (int k = 0; k < 9; k++) begin
      if (k == 0) c = 8'h01;
      else if (k == 1) c = 8'h42;
      else c = rnd_cmd ? 8'($urandom) : 8'h00;
      push_resp(k, b, s);
      xfer_byte(c, 8);
      if (k == 2 && chg) begin
        button_state = b_mid;
        stick_state = $urandom;
      end
      if (k < 8) begin
        wait_ack(got);
        check("ack_seen", {31'b0, got}, 1);
      end
    end
    cycles(6);
    check("poll_done_count", done_pulses - d0, 1);
    check("ack_count", ack_pulses - a0, 8);
    check("active_after_last", active, 0);
    check("data_after_last", data, 1);
    end_poll();
  endtask

  task automatic bad_cmd_poll(input int bad_byte, input logic [7:0] bad);
    int a0;
    bit got;
    a0 = ack_pulses;
    button_state = $urandom;
    stick_state = $urandom;
    start_poll();
    for (int k = 0; k <= bad_byte; k++) begin
      push_resp(k, button_state, stick_state);
      xfer_byte((k == bad_byte) ? bad : ((k == 0) ? 8'h01 : 8'h42), 8);
      if (k < bad_byte) begin
        wait_ack(got);
        check("ack_seen", {31'b0, got}, 1);
      end
    end
    cycles(ACK_DELAY + ACK_WIDTH + 10);
    check("ignore_ack_count", ack_pulses - a0, bad_byte);
    check("ignore_active", active, 0);
    check("ignore_data", data, 1);
    exp_q.push_back(8'hFF);
    xfer_byte(8'h00, 8);
    check("ignore_still_inactive", active, 0);
    end_poll();
  endtask

  task automatic abort_poll(input int nbits);
    bit got;
    logic [7:0] c;
    button_state = 16'h0000;
    stick_state = $urandom;
    start_poll();
    for (int k = 0; k < 4; k++) begin
      push_resp(k, button_state, stick_state);
      xfer_byte((k == 0) ? 8'h01 : ((k == 1) ? 8'h42 : 8'h00), 8);
      wait_ack(got);
      check("ack_seen", {31'b0, got}, 1);
    end
    c = 8'($urandom);
    xfer_byte(c, nbits);
    check("pre_abort_data", data, 0);
    @(negedge clk);
    att = 1'b1;
    cycles(3);
    check("abort_data", data, 1);
    check("abort_ack", ack, 1);
    check("abort_active", active, 0);
    cycles(3);
  endtask

  task automatic reset_in_ack();
    int t, d0;
    d0 = done_pulses;
    button_state = $urandom;
    stick_state = $urandom;
    start_poll();
    push_resp(0, button_state, stick_state);
    xfer_byte(8'h01, 8);
    t = 0;
    while (ack !== 1'b0 && t < ACK_DELAY + 20) begin
      @(negedge clk);
      t++;
    end
    check("ack_low_reached", ack, 0);
    cycles(1);
    rst_n = 1'b0;
    #1;
    check("rst_ack", ack, 1);
    check("rst_data", data, 1);
    check("rst_active", active, 0);
    check("rst_poll_done", poll_done, 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    check("post_reset_idle", active, 0);
    check("post_reset_no_done", done_pulses - d0, 0);
    end_poll();
  endtask

  initial begin : main
    logic [7:0] bad;
    rst_n = 1'b0;
    cycles(3);
    check("reset_data", data, 1);
    check("reset_ack", ack, 1);
    check("reset_active", active, 0);
    check("reset_poll_done", poll_done, 0);
    rst_n = 1'b1;
    cycles(10);
    check("idle_active", active, 0);

    full_poll(16'hFFFE, 32'h80808080, 1'b0, 16'hFFFE, 1'b0);

    bad_cmd_poll(0, 8'h81);
    full_poll(16'($urandom), $urandom, 1'b0, 16'h0, 1'b1);

    bad = 8'($urandom);
    if (bad == 8'h42) bad = 8'h43;
    bad_cmd_poll(1, bad);

    abort_poll($urandom_range(1, 7));
    full_poll(16'($urandom), $urandom, 1'b0, 16'h0, 1'b1);

    full_poll(16'hFFFF, 32'h80808080, 1'b1, 16'h0000, 1'b0);
    full_poll(16'h0000, 32'h80808080, 1'b0, 16'h0000, 1'b0);

    reset_in_ack();
    full_poll(16'($urandom), $urandom, 1'b0, 16'h0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      full_poll(16'($urandom), $urandom, 1'b1, 16'($urandom), 1'b1);
    end

    cycles(10);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #50_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psx_controller.md
PSX_CONTROLLER -- requirements
Module: psx_controller

Interface
REQ-001 Parameter ACK_DELAY, default 10, clk cycles from the 8th psx_clk rising edge of a byte to ack assertion (5 us at 500 ns/cycle).
REQ-002 Parameter ACK_WIDTH, default 4, clk cycles ack is held low (2 us).
REQ-003 Parameter DEVICE_ID, default 8'h73, ID byte returned during byte 1 (analog pad).
REQ-004 clk  input  1  system clock, 2 MHz nominal; one clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 att  input  1  console select, active low, asynchronous to clk.
REQ-007 psx_clk  input  1  console serial clock, idle high, asynchronous to clk.
REQ-008 cmd  input  1  console command bit, LSB first, asynchronous to clk.
REQ-009 button_state  input  16  button levels, active low (1 = released).
REQ-010 stick_state  input  32  {rx, ry, lx, ly}, 8'h80 = centre.
REQ-011 data  output  1  response bit to console, LSB first, idle 1.
REQ-012 ack  output  1  per-byte acknowledge, active low, idle 1.
REQ-013 active  output  1  high while a poll is accepted and in progress.
REQ-014 poll_done  output  1  one-cycle pulse after byte 8 completes.

Function
REQ-015 att, psx_clk and cmd SHALL pass through 2-flop synchronizers before use; edges are detected on synchronized signals.
REQ-016 States SHALL be IDLE, XFER, ACK_WAIT, ACK_LOW, IGNORE.
REQ-017 IDLE: on synchronized att falling edge -> XFER, byte_idx=0, bit_idx=0; button_state/stick_state SHALL be snapshotted in the same cycle and held for the whole poll.
REQ-018 Response bytes by byte_idx: 0=8'hFF, 1=DEVICE_ID, 2=8'h5A, 3=button_state[7:0], 4=button_state[15:8], 5=rx, 6=ry, 7=lx, 8=ly.
REQ-019 XFER: on synchronized psx_clk falling edge, data SHALL present bit bit_idx of the current response byte on the next clk cycle (≤3 cycles after the pin edge).
REQ-020 XFER: on synchronized psx_clk rising edge, cmd SHALL be shifted into an 8-bit command register at bit bit_idx; bit_idx increments, wrapping 7->0.
REQ-021 After the 8th rising edge of byte 0, a command value other than 8'h01 SHALL -> IGNORE with no ack.
REQ-022 After the 8th rising edge of byte 1, a command value other than 8'h42 SHALL -> IGNORE with no ack.
REQ-023 After the 8th rising edge of bytes 0..7 (valid commands), -> ACK_WAIT; after byte 8 -> IGNORE, data=1, poll_done pulses once, no ack.
REQ-024 ACK_WAIT: count ACK_DELAY cycles -> ACK_LOW; ACK_LOW: ack=0 for ACK_WIDTH cycles, then ack=1, byte_idx increments, -> XFER.
REQ-025 psx_clk edges arriving during ACK_WAIT/ACK_LOW SHALL be ignored.
REQ-026 IGNORE: data=1, ack=1, active=0; leave only on synchronized att high -> IDLE.
REQ-027 Synchronized att high in any state SHALL force IDLE, data=1, ack=1, active=0 on the next cycle, aborting any poll and ack pulse.
REQ-028 active SHALL be 1 in XFER, ACK_WAIT, ACK_LOW, else 0.
REQ-029 data SHALL be 1 whenever not in XFER; it only changes on psx_clk falling edges while in XFER.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, data=1, ack=1, active=0, poll_done=0, byte_idx=0, bit_idx=0, snapshot=all ones buttons and 8'h80 sticks, synchronizers to 1.
REQ-031 After rst_n deasserts with att already low, the block SHALL remain in IDLE until att goes high and then falls again.

Structure
REQ-032 Shared package psx_pkg SHALL hold START_CMD 8'h01, BEGIN_TX_CMD 8'h42, PREAMBLE 8'h5A, DEFAULT_ID 8'h73, NUM_BYTES 9 and the state encoding.
REQ-033 One sub-module psx_sync (2-flop synchronizer with rise/fall pulse outputs) SHALL be instantiated for att, psx_clk and cmd.

Verification
REQ-034 Full poll, cmds 01,42,00x7, buttons 16'hFFFE, sticks 32'h80808080 -> data bytes FF,73,5A,FE,FF,80,80,80,80; exactly 8 ack pulses of 4 cycles; one poll_done.
REQ-035 Byte 0 cmd 8'h81 -> no ack, data stays 1, active falls; next valid poll after att high succeeds.
REQ-036 att raised mid-byte 4 -> data=1, ack=1 within 3 cycles; next poll restarts at byte 0 with 8'hFF.
REQ-037 button_state changes from 16'hFFFF to 16'h0000 after byte 2 -> bytes 3,4 report FF,FF; following poll reports 00,00.
REQ-038 rst_n pulsed low during ACK_LOW -> ack=1, data=1 immediately, no poll_done, state IDLE.
